// File: rtl/dma_mc_pkg.sv
// Shared types for the multi-channel DMA controller: FSM states, direction
// encoding and the memory write-enable pattern.
package dma_mc_pkg;
    typedef enum logic [3:0] {
        S_IDLE, S_ARB, S_RD_MEM, S_RD_CAP, S_RD_DEV,
        S_WR_DEV, S_WR_MEM, S_STEP, S_DONE, S_ERR
    } state_t;

    typedef enum logic {
        DIR_WR = 1'b0,
        DIR_RD = 1'b1
    } dir_t;

    localparam logic [1:0] DMA_WE_WORD = 2'b11;
endpackage

// File: rtl/dma_mc_arbiter.sv
// Channel arbiter: fixed priority (lowest index) by default, round-robin
// starting after the last grant when DMA_MC_RR_ARB_EN is defined.
module dma_mc_arbiter
    import dma_mc_pkg::*;
#(
    parameter  int NUM_CH = 4,
    localparam int IDX_W  = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] req,
    input  logic              advance,
    output logic [NUM_CH-1:0] grant,
    output logic [IDX_W-1:0]  idx
);
`ifdef DMA_MC_RR_ARB_EN
    logic [IDX_W-1:0] ptr;

    // Walk downward so the candidate closest to ptr is the one left standing.
    always_comb begin
        int c;
        c     = 0;
        idx   = '0;
        grant = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            c = (int'(ptr) + i) % NUM_CH;
            if (req[c]) idx = IDX_W'(c);
        end
        if (|req) grant[idx] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ptr <= '0;
        else if (advance && |req)
            ptr <= (idx == IDX_W'(NUM_CH - 1)) ? '0 : idx + IDX_W'(1);
    end
`else
    logic unused_rr;
    assign unused_rr = ^{clk, reset, advance};

    always_comb begin
        idx   = '0;
        grant = '0;
        for (int i = NUM_CH - 1; i >= 0; i--)
            if (req[i]) idx = IDX_W'(i);
        if (|req) grant[idx] = 1'b1;
    end
`endif
endmodule

// File: rtl/dma_mc_controller.sv
// Multi-channel DMA engine for the openMSP430 DMA port: per-channel saved
// contexts, burst-bounded arbitration (DMA_MC_RR_ARB_EN selects round-robin).
module dma_mc_controller
    import dma_mc_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int ADD_LEN   = 15,
    parameter int DATA_LEN  = 16,
    parameter int CNT_LEN   = 16,
    parameter int BURST_LEN = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_CH-1:0]            ch_rqst,
    input  logic [NUM_CH-1:0]            ch_rd_wr,
    input  logic [NUM_CH*ADD_LEN-1:0]    ch_start_addr,
    input  logic [NUM_CH*CNT_LEN-1:0]    ch_num_words,
    input  logic [NUM_CH*DATA_LEN-1:0]   dev_in,
    input  logic [NUM_CH-1:0]            dev_valid,
    input  logic [NUM_CH-1:0]            dev_ready,
    output logic [DATA_LEN-1:0]          dev_out,
    output logic [NUM_CH-1:0]            dev_out_valid,
    output logic [NUM_CH-1:0]            dev_in_ack,
    output logic [NUM_CH-1:0]            ch_busy,
    output logic [NUM_CH-1:0]            ch_done,
    output logic [NUM_CH-1:0]            ch_err,
    input  logic [DATA_LEN-1:0]          dma_in,
    input  logic                         dma_ready,
    input  logic                         dma_resp,
    output logic [ADD_LEN-1:0]           dma_addr,
    output logic [DATA_LEN-1:0]          dma_out,
    output logic                         dma_en,
    output logic [1:0]                   dma_we,
    output logic                         dma_priority
);
    localparam int IDX_W = $clog2(NUM_CH);
    localparam int BW    = $clog2(BURST_LEN + 1);

    state_t              state;
    logic [ADD_LEN-1:0]  ctx_addr [NUM_CH];
    logic [CNT_LEN-1:0]  ctx_rem  [NUM_CH];
    logic [NUM_CH-1:0]   ctx_dir;
    logic [NUM_CH-1:0]   rqst_q;
    logic [IDX_W-1:0]    gidx;
    logic [NUM_CH-1:0]   g_oh;
    logic [BW-1:0]       burst;
    logic [NUM_CH-1:0]   arb_grant;
    logic [IDX_W-1:0]    arb_idx;

    assign dma_priority = 1'b0;

    dma_mc_arbiter #(.NUM_CH(NUM_CH)) u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (ch_busy),
        .advance (state == S_ARB),
        .grant   (arb_grant),
        .idx     (arb_idx)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            gidx          <= '0;
            g_oh          <= '0;
            burst         <= '0;
            rqst_q        <= '0;
            ch_busy       <= '0;
            ctx_dir       <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                ctx_addr[c] <= '0;
                ctx_rem[c]  <= '0;
            end
            dma_en        <= 1'b0;
            dma_we        <= '0;
            dma_addr      <= '0;
            dma_out       <= '0;
            dev_out       <= '0;
            dev_out_valid <= '0;
            dev_in_ack    <= '0;
            ch_done       <= '0;
            ch_err        <= '0;
        end else begin
            rqst_q     <= ch_rqst;
            dev_in_ack <= '0;
            ch_done    <= '0;
            ch_err     <= '0;

            // Loads only touch idle channels, so they never collide with the FSM.
            for (int c = 0; c < NUM_CH; c++) begin
                if (ch_rqst[c] && !rqst_q[c] && !ch_busy[c]) begin
                    if (ch_num_words[c*CNT_LEN +: CNT_LEN] == '0) begin
                        ch_err[c] <= 1'b1;
                    end else begin
                        ctx_addr[c] <= ch_start_addr[c*ADD_LEN +: ADD_LEN];
                        ctx_rem[c]  <= ch_num_words[c*CNT_LEN +: CNT_LEN];
                        ctx_dir[c]  <= ch_rd_wr[c];
                        ch_busy[c]  <= 1'b1;
                    end
                end
            end

            case (state)
                S_IDLE: if (|ch_busy) state <= S_ARB;
                S_ARB: begin
                    if (|ch_busy) begin
                        gidx  <= arb_idx;
                        g_oh  <= arb_grant;
                        burst <= '0;
                        if (dir_t'(ctx_dir[arb_idx]) == DIR_RD) begin
                            state    <= S_RD_MEM;
                            dma_en   <= 1'b1;
                            dma_addr <= ctx_addr[arb_idx];
                        end else begin
                            state <= S_WR_DEV;
                        end
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_RD_MEM, S_WR_MEM: begin
                    if (dma_resp || dma_ready) begin
                        dma_en   <= 1'b0;
                        dma_we   <= '0;
                        dma_addr <= '0;
                        dma_out  <= '0;
                        if (dma_resp)               state <= S_ERR;
                        else if (state == S_RD_MEM) state <= S_RD_CAP;
                        else                        state <= S_STEP;
                    end
                end
                // Memory returns read data the cycle after the accepted access.
                S_RD_CAP: begin
                    dev_out       <= dma_in;
                    dev_out_valid <= g_oh;
                    state         <= S_RD_DEV;
                end
                S_RD_DEV: begin
                    if (dev_ready[gidx]) begin
                        dev_out       <= '0;
                        dev_out_valid <= '0;
                        state         <= S_STEP;
                    end
                end
                S_WR_DEV: begin
                    if (dev_valid[gidx]) begin
                        dev_in_ack <= g_oh;
                        dma_en     <= 1'b1;
                        dma_we     <= DMA_WE_WORD;
                        dma_addr   <= ctx_addr[gidx];
                        dma_out    <= dev_in[gidx*DATA_LEN +: DATA_LEN];
                        state      <= S_WR_MEM;
                    end
                end
                S_STEP: begin
                    ctx_addr[gidx] <= ctx_addr[gidx] + ADD_LEN'(1);
                    ctx_rem[gidx]  <= ctx_rem[gidx] - CNT_LEN'(1);
                    burst          <= burst + BW'(1);
                    if (ctx_rem[gidx] == CNT_LEN'(1)) begin
                        state <= S_DONE;
                    end else if (burst + BW'(1) == BW'(BURST_LEN)) begin
                        state <= S_ARB;
                    end else if (dir_t'(ctx_dir[gidx]) == DIR_RD) begin
                        state    <= S_RD_MEM;
                        dma_en   <= 1'b1;
                        dma_addr <= ctx_addr[gidx] + ADD_LEN'(1);
                    end else begin
                        state <= S_WR_DEV;
                    end
                end
                S_DONE: begin
                    ch_done[gidx] <= 1'b1;
                    ch_busy[gidx] <= 1'b0;
                    state         <= S_IDLE;
                end
                S_ERR: begin
                    ch_err[gidx]  <= 1'b1;
                    ch_busy[gidx] <= 1'b0;
                    state         <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dma_mc_controller.sv
// Directed self-checking bench for dma_mc_controller (BURST_LEN=2); grant
// order expectations follow DMA_MC_RR_ARB_EN.
module tb_dma_mc_controller;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  ch_rqst, ch_rd_wr, dev_valid, dev_ready;
    logic [59:0] ch_start_addr;
    logic [63:0] ch_num_words, dev_in;
    logic [15:0] dev_out, dma_in, dma_out;
    logic [3:0]  dev_out_valid, dev_in_ack, ch_busy, ch_done, ch_err;
    logic        dma_ready, dma_resp, dma_en, dma_priority;
    logic [14:0] dma_addr;
    logic [1:0]  dma_we;

    int checks = 0, errors = 0;
    logic stall_mode = 1'b0, err_arm = 1'b0;
    int wcnt = 0, wr_acc = 0, err_at = 0;
    int done_cnt[4] = '{0, 0, 0, 0};
    int err_cnt[4]  = '{0, 0, 0, 0};
    int ack_cnt[4]  = '{0, 0, 0, 0};
    int wr_seq[4]   = '{0, 0, 0, 0};
    int stab_viol = 0, oh_viol = 0;
    int rd_ch[$];
    logic [15:0] rd_dat[$], wd[$];
    logic [14:0] ra[$], wa[$];

    dma_mc_controller #(.NUM_CH(4), .ADD_LEN(15), .DATA_LEN(16), .CNT_LEN(16), .BURST_LEN(2)) dut (
        .clk(clk), .reset(reset), .ch_rqst(ch_rqst), .ch_rd_wr(ch_rd_wr),
        .ch_start_addr(ch_start_addr), .ch_num_words(ch_num_words), .dev_in(dev_in),
        .dev_valid(dev_valid), .dev_ready(dev_ready), .dev_out(dev_out),
        .dev_out_valid(dev_out_valid), .dev_in_ack(dev_in_ack), .ch_busy(ch_busy),
        .ch_done(ch_done), .ch_err(ch_err), .dma_in(dma_in), .dma_ready(dma_ready),
        .dma_resp(dma_resp), .dma_addr(dma_addr), .dma_out(dma_out), .dma_en(dma_en),
        .dma_we(dma_we), .dma_priority(dma_priority)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] rd_val(input logic [14:0] a);
        return {1'b0, a} - 16'h0060;
    endfunction

    // Memory model: optional 2-cycle stall, armed error on a chosen write.
    always_comb dma_ready = !stall_mode || (wcnt == 2);
    always_comb dma_resp  = err_arm && dma_en && (dma_we == 2'b11) && (wr_acc == err_at);
    always_comb
        for (int c = 0; c < 4; c++)
            dev_in[c*16 +: 16] = 16'hC000 | (16'(c) << 8) | 16'(wr_seq[c] & 8'hFF);

    always @(posedge clk) begin
        if (dma_en && !dma_ready && !dma_resp) wcnt <= wcnt + 1;
        else wcnt <= 0;
        if (dma_en && dma_we == 2'b11 && (dma_ready || dma_resp)) wr_acc <= wr_acc + 1;
        if (dma_en && dma_ready && !dma_resp && dma_we == 2'b00) dma_in <= rd_val(dma_addr);
    end

    logic        pen = 1'b0, prdy = 1'b0;
    logic [32:0] pbus = '0;
    always @(negedge clk) begin
        for (int c = 0; c < 4; c++) begin
            done_cnt[c] += int'(ch_done[c]);
            err_cnt[c]  += int'(ch_err[c]);
            ack_cnt[c]  += int'(dev_in_ack[c]);
            if (dev_in_ack[c]) wr_seq[c]++;
            if (dev_out_valid[c] && dev_ready[c]) begin
                rd_ch.push_back(c);
                rd_dat.push_back(dev_out);
            end
        end
        if (dma_en && dma_ready && !dma_resp) begin
            if (dma_we == 2'b11) begin wa.push_back(dma_addr); wd.push_back(dma_out); end
            else ra.push_back(dma_addr);
        end
        if (pen && !prdy && dma_en && {dma_addr, dma_out, dma_we} != pbus) stab_viol++;
        if ($countones(dev_out_valid) > 1 || $countones(dev_in_ack) > 1) oh_viol++;
        pen  = dma_en;
        prdy = dma_ready;
        pbus = {dma_addr, dma_out, dma_we};
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_ch(input int c, input logic rd, input logic [14:0] a, input logic [15:0] n);
        ch_rd_wr[c]             = rd;
        ch_start_addr[c*15 +: 15] = a;
        ch_num_words[c*16 +: 16]  = n;
    endtask

    task automatic wait_quiet(input string tag, input int max);
        int n = 0;
        while (ch_busy != 0 && n < max) begin tick(); n++; end
        chk(tag, 32'(n < max), 1);
        repeat (2) tick();
    endtask

    int s_rd, s_ra, s_wa, d0, d1, d2, e1, e2, a1, q1, sv, k0, k2;
    int exp_seq[10];
    logic found;

    initial begin
        ch_rqst = '0; ch_rd_wr = '0; ch_start_addr = '0; ch_num_words = '0;
        dev_valid = 4'hF; dev_ready = 4'hF;
        repeat (3) tick();
        chk("rst dma_en", dma_en, 0);
        chk("rst dma_addr", dma_addr, 0);
        chk("rst ch_busy", ch_busy, 0);
        chk("rst dev_out_valid", dev_out_valid, 0);
        chk("rst dma_we", dma_we, 0);
        chk("rst dma_priority", dma_priority, 0);
        reset = 1'b0;
        tick();
        chk("post-rst pulses", {ch_done, ch_err, dev_in_ack}, 0);

        // Single read: timing of the first word, then contents.
        s_rd = rd_ch.size(); s_ra = ra.size(); d0 = done_cnt[0];
        set_ch(0, 1'b1, 15'h100, 16'd3);
        ch_rqst[0] = 1'b1;
        tick();
        chk("t1 busy", ch_busy, 4'b0001);
        tick(); tick();
        chk("t1 rd_mem en", dma_en, 1);
        chk("t1 rd_mem addr", dma_addr, 15'h100);
        tick(); tick();
        chk("t1 valid lat", dev_out_valid, 4'b0001);
        chk("t1 first word", dev_out, 16'h00A0);
        wait_quiet("t1 timeout", 100);
        ch_rqst[0] = 1'b0;
        chk("t1 words", rd_ch.size() - s_rd, 3);
        for (int i = 0; i < 3; i++) begin
            chk("t1 data", rd_dat[s_rd+i], 16'h00A0 + 16'(i));
            chk("t1 addr", ra[s_ra+i], 15'h100 + 15'(i));
        end
        chk("t1 done", done_cnt[0] - d0, 1);

        // Write with 2 stall cycles per access.
        s_wa = wa.size(); d1 = done_cnt[1]; a1 = ack_cnt[1]; q1 = wr_seq[1]; sv = stab_viol;
        stall_mode = 1'b1;
        set_ch(1, 1'b0, 15'h200, 16'd4);
        ch_rqst[1] = 1'b1;
        tick();
        wait_quiet("t2 timeout", 200);
        ch_rqst[1] = 1'b0;
        stall_mode = 1'b0;
        chk("t2 writes", wa.size() - s_wa, 4);
        for (int i = 0; i < 4; i++) begin
            chk("t2 addr", wa[s_wa+i], 15'h200 + 15'(i));
            chk("t2 data", wd[s_wa+i], 16'hC100 | 16'((q1 + i) & 8'hFF));
        end
        chk("t2 stable", stab_viol - sv, 0);
        chk("t2 acks", ack_cnt[1] - a1, 4);
        chk("t2 done", done_cnt[1] - d1, 1);

        // Zero-word request.
        set_ch(3, 1'b1, 15'h300, 16'd0);
        ch_rqst[3] = 1'b1;
        tick();
        chk("t3 err pulse", ch_err, 4'b1000);
        chk("t3 not busy", ch_busy, 0);
        tick();
        chk("t3 err cleared", ch_err, 0);
        tick();
        chk("t3 no dma_en", dma_en, 0);
        ch_rqst[3] = 1'b0;

        // Error on the second write of ch1 while ch0 reads.
        s_rd = rd_ch.size(); s_wa = wa.size();
        d0 = done_cnt[0]; d1 = done_cnt[1]; e1 = err_cnt[1]; a1 = ack_cnt[1];
        set_ch(0, 1'b1, 15'h400, 16'd3);
        set_ch(1, 1'b0, 15'h500, 16'd4);
        err_at = wr_acc + 1;
        err_arm = 1'b1;
        ch_rqst[1:0] = 2'b11;
        tick();
        wait_quiet("t4 timeout", 200);
        err_arm = 1'b0;
        ch_rqst[1:0] = 2'b00;
        chk("t4 err1", err_cnt[1] - e1, 1);
        chk("t4 no done1", done_cnt[1] - d1, 0);
        chk("t4 done0", done_cnt[0] - d0, 1);
        chk("t4 writes", wa.size() - s_wa, 1);
        chk("t4 wr addr", wa[s_wa], 15'h500);
        chk("t4 acks", ack_cnt[1] - a1, 2);
        chk("t4 reads", rd_ch.size() - s_rd, 3);
        for (int i = 0; i < 3; i++) begin
            chk("t4 rd ch", rd_ch[s_rd+i], 0);
            chk("t4 rd data", rd_dat[s_rd+i], 16'h03A0 + 16'(i));
        end
        chk("t4 busy", ch_busy, 0);

        // Reset in the middle of a burst.
        set_ch(2, 1'b1, 15'h600, 16'd8);
        ch_rqst[2] = 1'b1;
        found = 1'b0;
        for (int n = 0; n < 30 && !found; n++) begin
            tick();
            found = (dev_out_valid != 0);
        end
        chk("t5 mid-burst", found, 1);
        d2 = done_cnt[2]; e2 = err_cnt[2];
        reset = 1'b1;
        ch_rqst = '0;
        #1;
        chk("t5 async en", dma_en, 0);
        tick();
        chk("t5 rst outs", {dev_out_valid, ch_busy, dev_out, dma_addr, dma_out, dma_en, dma_we}, 0);
        tick();
        reset = 1'b0;
        tick();
        chk("t5 no pulses", (done_cnt[2] - d2) + (err_cnt[2] - e2), 0);

        // Fresh request wrapping past the top of the address space.
        s_rd = rd_ch.size(); s_ra = ra.size(); d0 = done_cnt[0];
        set_ch(0, 1'b1, 15'h7FFF, 16'd2);
        ch_rqst[0] = 1'b1;
        tick();
        wait_quiet("t5 wrap timeout", 100);
        ch_rqst[0] = 1'b0;
        chk("t5 wrap a0", ra[s_ra], 15'h7FFF);
        chk("t5 wrap a1", ra[s_ra+1], 15'h0000);
        chk("t5 wrap d0", rd_dat[s_rd], 16'h7F9F);
        chk("t5 wrap d1", rd_dat[s_rd+1], 16'hFFA0);
        chk("t5 wrap done", done_cnt[0] - d0, 1);

        // Pre-emption at burst boundaries, from a clean arbiter state.
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        tick();
`ifdef DMA_MC_RR_ARB_EN
        exp_seq = '{0, 0, 2, 2, 0, 0, 2, 2, 0, 2};
`else
        exp_seq = '{0, 0, 0, 0, 0, 2, 2, 2, 2, 2};
`endif
        s_rd = rd_ch.size(); d0 = done_cnt[0]; d2 = done_cnt[2];
        set_ch(0, 1'b1, 15'h800, 16'd5);
        set_ch(2, 1'b1, 15'h0A00, 16'd5);
        ch_rqst = 4'b0101;
        tick();
        wait_quiet("t6 timeout", 300);
        ch_rqst = '0;
        chk("t6 words", rd_ch.size() - s_rd, 10);
        k0 = 0; k2 = 0;
        for (int i = 0; i < 10; i++) begin
            chk("t6 grant order", rd_ch[s_rd+i], exp_seq[i]);
            if (exp_seq[i] == 0) begin
                chk("t6 ch0 data", rd_dat[s_rd+i], 16'h07A0 + 16'(k0)); k0++;
            end else begin
                chk("t6 ch2 data", rd_dat[s_rd+i], 16'h09A0 + 16'(k2)); k2++;
            end
        end
        chk("t6 done0", done_cnt[0] - d0, 1);
        chk("t6 done2", done_cnt[2] - d2, 1);
        chk("onehot outputs", oh_viol, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
